// File: rtl/matvec_pkg.sv
// Shared types and sizing helpers for the matrix-vector engine.
package matvec_pkg;

    typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_X, RUN} state_t;

    function automatic int out_width(input int in_w, input int n);
        return 2 * in_w + $clog2(n);
    endfunction

    // Bits needed to count 0..depth-1, never less than one.
    function automatic int cnt_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/matvec_mac.sv
// Pipelined signed multiplier followed by a load/accumulate register.
// Valid/first/last tags ride alongside the product; one enable stalls everything.
module matvec_mac import matvec_pkg::*; #(
    parameter int IN_W        = 14,
    parameter int MULT_STAGES = 7,
    parameter int OUT_W       = 30
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    output logic signed [OUT_W-1:0] acc,
    output logic                    acc_done
);
    localparam int PW = 2 * IN_W;
    localparam int TW = PW + 3;

    logic signed [PW-1:0]    a_ext, b_ext, prod, s_prod;
    logic signed [OUT_W-1:0] s_ext;
    logic [TW-1:0]           stage_in, stage_out;
    logic                    s_valid, s_first, s_last;

    assign a_ext    = PW'(a);
    assign b_ext    = PW'(b);
    assign prod     = a_ext * b_ext;
    assign stage_in = {in_valid, in_first, in_last, prod};

    generate
        if (MULT_STAGES == 0) begin : g_comb
            assign stage_out = stage_in;
        end else begin : g_pipe
            logic [TW-1:0] pipe [MULT_STAGES];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < MULT_STAGES; i++) pipe[i] <= '0;
                end else if (en) begin
                    pipe[0] <= stage_in;
                    for (int i = 1; i < MULT_STAGES; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign stage_out = pipe[MULT_STAGES-1];
        end
    endgenerate

    assign {s_valid, s_first, s_last, s_prod} = stage_out;
    assign s_ext = OUT_W'(s_prod);

    // Loading on the first term of a row avoids a separate clear cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            acc_done <= 1'b0;
        end else if (en) begin
            acc_done <= s_valid & s_last;
            if (s_valid) acc <= s_first ? s_ext : acc + s_ext;
        end
    end

endmodule

// File: rtl/matvec_mxn.sv
// Matrix-vector engine y = W*x with streamed W/x loading and streamed row results.
// Define MATVEC_RELU_EN to clamp negative results to zero at the output register.
module matvec_mxn import matvec_pkg::*; #(
    parameter  int M           = 3,
    parameter  int N           = 3,
    parameter  int IN_W        = 14,
    parameter  int MULT_STAGES = 7,
    localparam int OUT_W       = out_width(IN_W, N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             input_valid,
    output logic             input_ready,
    input  logic [IN_W-1:0]  input_data,
    input  logic             new_matrix,
    output logic             output_valid,
    input  logic             output_ready,
    output logic [OUT_W-1:0] output_data
);
    localparam int MN = M * N;
    localparam int KW = cnt_width(MN);
    localparam int JW = cnt_width(N);
    localparam int RW = cnt_width(M);

    // Handshake: a beat moves on a rising edge where valid and ready are both high;
    // ready never depends on valid, and a stalled output holds data and valid steady.
    state_t                  state, state_next;
    logic                    mat_loaded, iss_done;
    logic [KW-1:0]           ld_cnt, w_idx;
    logic [RW-1:0]           iss_r, out_cnt;
    logic [JW-1:0]           iss_j;
    logic signed [IN_W-1:0]  w_mem [MN];
    logic signed [IN_W-1:0]  x_mem [N];
    logic signed [IN_W-1:0]  rd_w, rd_x;
    logic                    rd_valid, rd_first, rd_last;
    logic signed [OUT_W-1:0] acc, y_out;
    logic                    acc_done;
    logic                    in_fire, out_fire, stall, wr_w, wr_x, last_w, last_x, issue;

    assign in_fire  = input_valid & input_ready;
    assign out_fire = output_valid & output_ready;
    assign stall    = output_valid & ~output_ready;
    assign wr_w     = in_fire & ((state == LOAD_W) | ((state == IDLE) & (new_matrix | ~mat_loaded)));
    assign wr_x     = in_fire & ~wr_w;
    assign last_w   = (ld_cnt == KW'(MN - 1));
    assign last_x   = (ld_cnt == KW'(N - 1));
    assign issue    = (state == RUN) & ~iss_done & ~stall;
    assign w_idx    = KW'(iss_r * N + iss_j);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        input_ready = 1'b1;
        case (state)
            IDLE, LOAD_W, LOAD_X: begin
                if (wr_w && last_w)      state_next = LOAD_X;
                else if (wr_w)           state_next = LOAD_W;
                else if (wr_x && last_x) state_next = RUN;
                else if (wr_x)           state_next = LOAD_X;
            end
            RUN: begin
                input_ready = 1'b0;
                if (out_fire && out_cnt == RW'(M - 1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_cnt     <= '0;
            mat_loaded <= 1'b0;
        end else if (wr_w) begin
            ld_cnt <= last_w ? '0 : ld_cnt + 1'b1;
            if (last_w) mat_loaded <= 1'b1;
        end else if (wr_x) begin
            ld_cnt <= last_x ? '0 : ld_cnt + 1'b1;
        end
    end

    // Storage has no reset: contents are always rewritten before use.
    always_ff @(posedge clk) begin
        if (wr_w) w_mem[ld_cnt] <= input_data;
        if (wr_x) x_mem[ld_cnt[JW-1:0]] <= input_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iss_r    <= '0;
            iss_j    <= '0;
            iss_done <= 1'b0;
        end else if (state != RUN) begin
            iss_r    <= '0;
            iss_j    <= '0;
            iss_done <= 1'b0;
        end else if (issue) begin
            if (iss_j == JW'(N - 1)) begin
                iss_j <= '0;
                if (iss_r == RW'(M - 1)) iss_done <= 1'b1;
                else                     iss_r    <= iss_r + 1'b1;
            end else begin
                iss_j <= iss_j + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_first <= 1'b0;
            rd_last  <= 1'b0;
            rd_w     <= '0;
            rd_x     <= '0;
        end else if (!stall) begin
            rd_valid <= issue;
            rd_first <= (iss_j == '0);
            rd_last  <= (iss_j == JW'(N - 1));
            rd_w     <= w_mem[w_idx];
            rd_x     <= x_mem[iss_j];
        end
    end

    matvec_mac #(
        .IN_W        (IN_W),
        .MULT_STAGES (MULT_STAGES),
        .OUT_W       (OUT_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .en       (~stall),
        .in_valid (rd_valid),
        .in_first (rd_first),
        .in_last  (rd_last),
        .a        (rd_w),
        .b        (rd_x),
        .acc      (acc),
        .acc_done (acc_done)
    );

    always_comb begin
`ifdef MATVEC_RELU_EN
        y_out = acc[OUT_W-1] ? '0 : acc;
`else
        y_out = acc;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            output_valid <= 1'b0;
            output_data  <= '0;
        end else if (!stall) begin
            output_valid <= acc_done;
            if (acc_done) output_data <= y_out;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)              out_cnt <= '0;
        else if (state != RUN)  out_cnt <= '0;
        else if (out_fire)      out_cnt <= (out_cnt == RW'(M - 1)) ? '0 : out_cnt + 1'b1;
    end

endmodule

// File: tb/tb_matvec_mxn.sv
// Bench for matvec_mxn: directed table, backpressure and reset-abort sequences, random jobs
// checked against a plain-arithmetic reference model.
module tb_matvec_mxn;
    localparam int M = 3, N = 3, IN_W = 14, S = 7;
    localparam int OUT_W = 2 * IN_W + $clog2(N);
    localparam int MN = M * N;
    localparam int LAT = N + S + 2;

    typedef logic [MN-1:0][IN_W-1:0] wvec_t;
    typedef logic [N-1:0][IN_W-1:0]  xvec_t;
    typedef logic [M-1:0][OUT_W-1:0] yvec_t;
    typedef struct {
        logic  nm;
        wvec_t w;
        xvec_t x;
        yvec_t y;
    } vec_t;

    logic             clk = 1'b0, reset = 1'b1;
    logic             input_valid = 1'b0, new_matrix = 1'b0, output_ready = 1'b1;
    logic             input_ready, output_valid;
    logic [IN_W-1:0]  input_data = '0;
    logic [OUT_W-1:0] output_data;

    int               n_vec = 0, n_err = 0, out_seen = 0;
    bit               rand_bp = 1'b0;
    logic [OUT_W-1:0] exp_q[$];
    logic signed [IN_W-1:0] mdl_w [MN];
    logic             mdl_loaded = 1'b0;
    vec_t             tbl[6];

    always #5 clk = ~clk;

    matvec_mxn #(.M(M), .N(N), .IN_W(IN_W), .MULT_STAGES(S)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .new_matrix   (new_matrix),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OUT_W-1:0] post(input longint y);
`ifdef MATVEC_RELU_EN
        if (y < 0) y = 0;
`endif
        return OUT_W'(y);
    endfunction

    function automatic xvec_t mkx(input int a, input int b, input int c);
        xvec_t x;
        x[0] = IN_W'(a); x[1] = IN_W'(b); x[2] = IN_W'(c);
        return x;
    endfunction

    function automatic yvec_t mky(input longint a, input longint b, input longint c);
        yvec_t y;
        y[0] = OUT_W'(a); y[1] = OUT_W'(b); y[2] = OUT_W'(c);
        return y;
    endfunction

    // Reference: y[r] = sum_j W[r][j]*x[j] in wide integer arithmetic.
    task automatic push_model(input xvec_t x);
        for (int r = 0; r < M; r++) begin
            longint s = 0;
            for (int j = 0; j < N; j++) s += longint'(mdl_w[r*N+j]) * longint'($signed(x[j]));
            exp_q.push_back(post(s));
        end
    endtask

    task automatic load_model(input wvec_t w);
        for (int k = 0; k < MN; k++) mdl_w[k] = $signed(w[k]);
        mdl_loaded = 1'b1;
    endtask

    function automatic wvec_t rand_w();
        wvec_t w;
        for (int k = 0; k < MN; k++) w[k] = IN_W'($urandom_range(0, (1 << IN_W) - 1));
        return w;
    endfunction

    function automatic xvec_t rand_x();
        xvec_t x;
        for (int j = 0; j < N; j++) x[j] = IN_W'($urandom_range(0, (1 << IN_W) - 1));
        return x;
    endfunction

    always @(negedge clk) begin
        if (!reset && output_valid && output_ready) begin
            out_seen++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got 0x%0h, expected none at %0t", output_data, $time);
            end else begin
                check("y_data", output_data, exp_q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            output_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        output_ready = v;
    endtask

    task automatic send_beat(input logic [IN_W-1:0] d, input logic nm, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        input_valid = 1'b1;
        input_data  = d;
        new_matrix  = nm;
        while (!input_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!input_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_timeout: input_ready low for %0d cycles, expected high", n);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        input_valid = 1'b0;
        new_matrix  = 1'b0;
    endtask

    // Later beats carry a random new_matrix to show it is ignored after the first beat.
    task automatic do_job(input logic nm, input logic send_w, input wvec_t w, input xvec_t x,
                          input int max_gap);
        bit first = 1'b1;
        if (send_w) begin
            for (int k = 0; k < MN; k++) begin
                send_beat(w[k], first ? nm : 1'($urandom_range(0, 1)), $urandom_range(0, max_gap));
                first = 1'b0;
            end
        end
        for (int j = 0; j < N; j++) begin
            send_beat(x[j], first ? nm : 1'($urandom_range(0, 1)), $urandom_range(0, max_gap));
            first = 1'b0;
        end
        check("ready_low_in_run", input_ready, 1'b0);
    endtask

    task automatic wait_latency();
        int n = 0;
        while (!output_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, LAT);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || output_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, base;
        logic [OUT_W-1:0] hold;
        wvec_t w;
        xvec_t x;
        logic  nm, sw;

        // Directed vectors; 8191 is the largest positive 14-bit value.
        for (int k = 0; k < MN; k++) tbl[0].w[k] = (k / N == k % N) ? IN_W'(1) : IN_W'(0);
        tbl[0].nm = 1'b1; tbl[0].x = mkx(5, -7, 8191);      tbl[0].y = mky(5, -7, 8191);
        tbl[1].nm = 1'b0; tbl[1].w = tbl[0].w;
        tbl[1].x = mkx(1, 2, 3);                            tbl[1].y = mky(1, 2, 3);
        for (int k = 0; k < MN; k++) tbl[2].w[k] = IN_W'(-8192);
        tbl[2].nm = 1'b1; tbl[2].x = mkx(-8192, -8192, -8192);
        tbl[2].y = mky(201326592, 201326592, 201326592);
        tbl[3].w = '0; tbl[3].w[0] = IN_W'(1); tbl[3].w[3] = IN_W'(-1);
        tbl[3].nm = 1'b1; tbl[3].x = mkx(4, 0, 0);           tbl[3].y = mky(4, -4, 0);
        tbl[4].nm = 1'b0; tbl[4].w = tbl[3].w;
        tbl[4].x = mkx(-8192, 8191, 7);                     tbl[4].y = mky(-8192, 8192, 0);
        for (int k = 0; k < MN; k++) tbl[5].w[k] = IN_W'(8191);
        tbl[5].nm = 1'b1; tbl[5].x = mkx(-8192, -8192, -8192);
        tbl[5].y = mky(-201302016, -201302016, -201302016);

        repeat (3) @(negedge clk);
        check("rst_output_valid", output_valid, 1'b0);
        check("rst_output_data", output_data, '0);
        check("rst_input_ready", input_ready, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check("idle_input_ready", input_ready, 1'b1);

        for (int v = 0; v < 6; v++) begin
            sw = tbl[v].nm | ~mdl_loaded;
            if (sw) load_model(tbl[v].w);
            for (int r = 0; r < M; r++) exp_q.push_back(post(longint'($signed(tbl[v].y[r]))));
            do_job(tbl[v].nm, sw, tbl[v].w, tbl[v].x, 0);
            wait_latency();
            wait_drain();
        end

        // Hold y[1] under backpressure for 10 cycles.
        w = rand_w();
        x = rand_x();
        load_model(w);
        push_model(x);
        base = out_seen;
        do_job(1'b1, 1'b1, w, x, 1);
        n = 0;
        while (out_seen < base + 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        set_ready(1'b0);
        @(negedge clk);
        n = 0;
        while (!output_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        hold = output_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_data", output_data, hold);
            check("bp_hold_valid", output_valid, 1'b1);
        end
        set_ready(1'b1);
        @(negedge clk);
        wait_drain();
        check("bp_result_count", out_seen - base, M);

        // Abort mid-row with reset; W must be reloaded afterwards even with new_matrix=0.
        w = rand_w();
        x = rand_x();
        do_job(1'b1, 1'b1, w, x, 0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_output_valid", output_valid, 1'b0);
        check("abort_output_data", output_data, '0);
        check("abort_input_ready", input_ready, 1'b1);
        exp_q.delete();
        mdl_loaded = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        w = rand_w();
        x = rand_x();
        load_model(w);
        push_model(x);
        do_job(1'b0, 1'b1, w, x, 0);
        wait_latency();
        wait_drain();

        // Random jobs with random input gaps and random output backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < 16; i++) begin
            nm = 1'($urandom_range(0, 1));
            sw = nm | ~mdl_loaded;
            w  = rand_w();
            x  = rand_x();
            if (sw) load_model(w);
            push_model(x);
            do_job(nm, sw, w, x, 2);
        end
        rand_bp = 1'b0;
        set_ready(1'b1);
        @(negedge clk);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
